// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: DIGITS nibbles, binary or BCD, wrap or saturate.
// Parallel load, count enable and a combinational terminal count for cascading.
module updown_counter_param #(
    parameter int DIGITS   = 2,
    parameter bit BCD      = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ctrl,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] MAX_VAL = BCD ? {DIGITS{4'h9}} : {W{1'b1}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_r;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd_step;
    logic [W-1:0] bin_step;
    logic [W-1:0] step_val;
    logic         at_max;
    logic         at_min;
    logic         at_limit;
    logic         hold_at_limit;

    // Loaded nibbles above 9 are clamped in BCD mode so every digit stays decimal.
    always_comb begin
        logic [3:0] nib;
        load_val = '0;
        nib      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = din[4*k +: 4];
            load_val[4*k +: 4] = (BCD && (nib > 4'd9)) ? 4'd9 : nib;
        end
    end

    // Ripple carry/borrow through the digits; wrapping at MAX or 0 falls out naturally.
    always_comb begin
        logic [3:0] nib;
        logic       carry;
        bcd_step = '0;
        nib      = '0;
        carry    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            nib = q_r[4*k +: 4];
            if (!carry) begin
                bcd_step[4*k +: 4] = nib;
            end else if (ctrl) begin
                bcd_step[4*k +: 4] = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
                carry              = (nib >= 4'd9);
            end else begin
                bcd_step[4*k +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                carry              = (nib == 4'd0);
            end
        end
    end

    always_comb begin
        bin_step      = ctrl ? (q_r + ONE) : (q_r - ONE);
        step_val      = BCD ? bcd_step : bin_step;
        at_max        = (q_r == MAX_VAL);
        at_min        = (q_r == '0);
        at_limit      = ctrl ? at_max : at_min;
        hold_at_limit = SATURATE && at_limit;
    end

    // tc is the carry/borrow of this stage: wire it to the next stage's en to
    // widen the counter; it is high in the cycle before the wrap/hold edge.
    assign tc = en & ~load & at_limit;
    assign q  = q_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_val;
        end else if (en && !hold_at_limit) begin
            q_r <= step_val;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four configurations driven in lockstep,
// checked against an arithmetic reference model through expected-value queues.
module tb_updown_counter_param;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic       ctrl = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din  = 8'h00;

    logic [7:0] q0, q2, q3;
    logic [3:0] q1;
    logic       tc0, tc1, tc2, tc3;

    logic [7:0] q_a [4];
    logic [3:0] tc_a;

    int cfg_dig [4] = '{2, 1, 2, 2};
    int cfg_bcd [4] = '{1, 0, 1, 0};
    int cfg_sat [4] = '{0, 0, 1, 1};

    logic [7:0]  mdl [4];
    logic [31:0] exp_q [$];
    logic [3:0]  exp_tc_q [$];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.DIGITS(2), .BCD(1'b1), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din), .q(q0), .tc(tc0));
    updown_counter_param #(.DIGITS(1), .BCD(1'b0), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din[3:0]), .q(q1), .tc(tc1));
    updown_counter_param #(.DIGITS(2), .BCD(1'b1), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din), .q(q2), .tc(tc2));
    updown_counter_param #(.DIGITS(2), .BCD(1'b0), .SATURATE(1'b1)) u3 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .din(din), .q(q3), .tc(tc3));

    always_comb begin
        q_a[0] = q0;
        q_a[1] = {4'h0, q1};
        q_a[2] = q2;
        q_a[3] = q3;
        tc_a   = {tc3, tc2, tc1, tc0};
    end

    // ---------------- reference model (decimal/binary integer arithmetic) ----------------
    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic int lim_max(input int i);
        if (cfg_bcd[i] != 0) return pow10(cfg_dig[i]) - 1;
        return (1 << (4 * cfg_dig[i])) - 1;
    endfunction

    function automatic int to_num(input int i, input logic [7:0] v);
        int n = 0;
        if (cfg_bcd[i] != 0) begin
            for (int k = 0; k < cfg_dig[i]; k++) n = n + int'(v[4*k +: 4]) * pow10(k);
        end else begin
            n = int'(v) & lim_max(i);
        end
        return n;
    endfunction

    function automatic logic [7:0] from_num(input int i, input int n);
        logic [7:0] r = '0;
        if (cfg_bcd[i] != 0) begin
            for (int k = 0; k < cfg_dig[i]; k++) r[4*k +: 4] = 4'((n / pow10(k)) % 10);
        end else begin
            r = 8'(n);
        end
        return r;
    endfunction

    function automatic logic [7:0] load_val(input int i, input logic [7:0] d);
        logic [7:0] r = '0;
        logic [3:0] nib;
        for (int k = 0; k < cfg_dig[i]; k++) begin
            nib = d[4*k +: 4];
            if (cfg_bcd[i] != 0 && nib > 4'd9) nib = 4'd9;
            r[4*k +: 4] = nib;
        end
        return r;
    endfunction

    function automatic logic model_tc(input int i, input logic e, input logic c, input logic l);
        int n = to_num(i, mdl[i]);
        return e && !l && ((c && n == lim_max(i)) || (!c && n == 0));
    endfunction

    function automatic logic [7:0] model_next(input int i, input logic e, input logic c,
                                              input logic l, input logic [7:0] d);
        int n;
        if (l) return load_val(i, d);
        if (!e) return mdl[i];
        n = to_num(i, mdl[i]);
        if (c) n = (n == lim_max(i)) ? ((cfg_sat[i] != 0) ? n : 0) : n + 1;
        else   n = (n == 0) ? ((cfg_sat[i] != 0) ? 0 : lim_max(i)) : n - 1;
        return from_num(i, n);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // q monitor: one expected word per rising edge, sampled just after it.
    always begin
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) check($sformatf("q[u%0d]", i), q_a[i], e[8*i +: 8]);
        end
    end

    // tc monitor: tc is combinational, so it is sampled after inputs settle mid-low phase.
    always begin
        logic [3:0] e;
        @(negedge clk);
        #2;
        if (exp_tc_q.size() > 0) begin
            e = exp_tc_q.pop_front();
            for (int i = 0; i < 4; i++) check($sformatf("tc[u%0d]", i), {7'd0, tc_a[i]}, {7'd0, e[i]});
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic c, input logic l, input logic [7:0] d);
        logic [31:0] pk;
        logic [3:0]  tk;
        @(negedge clk);
        en = e; ctrl = c; load = l; din = d;
        for (int i = 0; i < 4; i++) begin
            tk[i]         = model_tc(i, e, c, l);
            mdl[i]        = model_next(i, e, c, l, d);
            pk[8*i +: 8]  = mdl[i];
        end
        exp_tc_q.push_back(tk);
        exp_q.push_back(pk);
    endtask

    // Asynchronous reset in the middle of the low phase; q must clear without an edge.
    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_q[u%0d]", i), q_a[i], 8'h00);
            check($sformatf("async_rst_tc[u%0d]", i), {7'd0, tc_a[i]}, {7'd0, en & ~load & ~ctrl});
            mdl[i] = 8'h00;
        end
        exp_q.push_back(32'h0);
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;

        // Reset held from time zero; tc follows en/ctrl while q is forced to 0.
        #2;
        for (int i = 0; i < 4; i++) check($sformatf("reset_q[u%0d]", i), q_a[i], 8'h00);
        en = 1'b1; ctrl = 1'b0;
        #1;
        check("reset_tc_down", {4'd0, tc_a}, 8'h0F);
        ctrl = 1'b1;
        #1;
        check("reset_tc_up", {4'd0, tc_a}, 8'h00);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Count up through the 0x09 -> 0x10 carry.
        for (int n = 0; n < 12; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        // Wrap at 0x99, then reverse at 0x00.
        step(1'b0, 1'b1, 1'b1, 8'h98);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 2; n++) step(1'b1, 1'b0, 1'b0, 8'h00);
        // Clamped load and the 0x30 -> 0x29 borrow.
        step(1'b0, 1'b0, 1'b1, 8'h3F);
        for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b0, 8'h00);
        // Binary nibble wrap in both directions.
        step(1'b0, 1'b0, 1'b1, 8'h0E);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 2; n++) step(1'b1, 1'b0, 1'b0, 8'h00);
        // Saturation at both limits, then idle.
        step(1'b0, 1'b0, 1'b1, 8'h99);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 1'b0, 8'h00);
        // Reset mid-count at 0x47, then resume from 0.
        step(1'b0, 1'b0, 1'b1, 8'h40);
        for (int n = 0; n < 7; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        pulse_reset();
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 8'h00);
        // Load beats a count at the limit.
        step(1'b0, 1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 1'b0, 8'h00);

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0 && exp_tc_q.size() == 0) passes++;
        else $display("FAIL queue_drain: q left %0d tc left %0d expected 0 0", exp_q.size(), exp_tc_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
